// File: rtl/axi_sram_slave_if.sv
// AXI4 subset carried between the clock-domain bridge (master) and the SRAM slave.
// m_* signals are driven by the master, s_* signals by the slave.
interface axi4_interface #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m_awvalid;
  logic                  s_awready;
  logic [ADDR_WIDTH-1:0] m_awadr;
  logic [7:0]            m_awlen;
  logic                  m_wvalid;
  logic                  s_wready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_wlast;
  logic                  s_bvalid;
  logic                  m_bready;
  logic                  m_arvalid;
  logic                  s_arready;
  logic [ADDR_WIDTH-1:0] m_aradr;
  logic [7:0]            m_arlen;
  logic                  s_rvalid;
  logic                  m_rready;
  logic [DATA_WIDTH-1:0] s_rdata;

  modport master (
    output m_awvalid, m_awadr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
           m_arvalid, m_aradr, m_arlen, m_rready,
    input  s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );

  modport slave (
    input  m_awvalid, m_awadr, m_awlen, m_wvalid, m_wdata, m_wlast, m_bready,
           m_arvalid, m_aradr, m_arlen, m_rready,
    output s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rdata
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a synchronous single-port RAM: incrementing bursts,
// one transaction at a time, read/write collisions arbitrated by last-served.
module axi_sram_slave #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  axi4_interface.slave        axi_bus,
  output logic [1:0]          dbg_state
);
  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1.
  // Valids here come only from registered state; readies may look at the master's valids.

  localparam int OFF   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_SIZE);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WRITE_BURST = 2'd1;
  localparam logic [1:0] WRITE_RESP  = 2'd2;
  localparam logic [1:0] READ_BURST  = 2'd3;

  logic [1:0]            state;
  logic                  last_served_read;
  logic [IDX_W-1:0]      idx;
  logic [7:0]            beat_cnt;
  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic [IDX_W-1:0]      ram_addr;
  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rdata_q;

  logic grant_w, grant_r;
  logic awready, arready;
  logic aw_hs, ar_hs, w_hs, r_hs;
  logic ram_we, ram_re;
  logic unused_bits;

  assign aw_idx = axi_bus.m_awadr[OFF +: IDX_W];
  assign ar_idx = axi_bus.m_aradr[OFF +: IDX_W];

  // On a collision the type not served most recently wins.
  assign grant_w = axi_bus.m_awvalid && (!axi_bus.m_arvalid ||  last_served_read);
  assign grant_r = axi_bus.m_arvalid && (!axi_bus.m_awvalid || !last_served_read);

  assign awready = (state == IDLE) && grant_w;
  assign arready = (state == IDLE) && grant_r;

  assign aw_hs = awready && axi_bus.m_awvalid;
  assign ar_hs = arready && axi_bus.m_arvalid;
  assign w_hs  = (state == WRITE_BURST) && axi_bus.m_wvalid;
  assign r_hs  = (state == READ_BURST)  && axi_bus.m_rready;

  assign axi_bus.s_awready = awready;
  assign axi_bus.s_arready = arready;
  assign axi_bus.s_wready  = (state == WRITE_BURST);
  assign axi_bus.s_bvalid  = (state == WRITE_RESP);
  assign axi_bus.s_rvalid  = (state == READ_BURST);
  assign axi_bus.s_rdata   = rdata_q;
  assign dbg_state         = state;

  // The read port prefetches the next beat on each R handshake so a stream
  // with m_rready held high gets one beat per cycle; stalls leave rdata_q alone.
  assign ram_we   = w_hs;
  assign ram_re   = ar_hs || (r_hs && (beat_cnt != 8'd0));
  assign ram_addr = ar_hs ? ar_idx : (w_hs ? idx : idx + IDX_W'(1));

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= axi_bus.m_wdata;
    if (ram_re) rdata_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      last_served_read <= 1'b0;
      idx              <= '0;
      beat_cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            idx              <= aw_idx;
            beat_cnt         <= axi_bus.m_awlen;
            last_served_read <= 1'b0;
            state            <= WRITE_BURST;
          end else if (ar_hs) begin
            idx              <= ar_idx;
            beat_cnt         <= axi_bus.m_arlen;
            last_served_read <= 1'b1;
            state            <= READ_BURST;
          end
        end
        WRITE_BURST: begin
          // Burst length comes from the counter alone; m_wlast is not consulted.
          if (w_hs) begin
            idx      <= idx + IDX_W'(1);
            beat_cnt <= beat_cnt - 8'd1;
            if (beat_cnt == 8'd0) state <= WRITE_RESP;
          end
        end
        WRITE_RESP: begin
          if (axi_bus.m_bready) state <= IDLE;
        end
        READ_BURST: begin
          if (r_hs) begin
            if (beat_cnt == 8'd0) begin
              state <= IDLE;
            end else begin
              idx      <= idx + IDX_W'(1);
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unused_bits = &{1'b0, axi_bus.m_wlast, axi_bus.m_awadr, axi_bus.m_aradr};
endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 4096: memory depth in DATA_WIDTH words; a power of two.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: AXI byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data word width.
REQ-004 SHALL have port clk  input  1  single clock for all logic and memory (one clock; reset is asynchronous and active-high).
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port axi_bus  axi4_interface.slave  -  AXI4 slave terminating the master side of the clock-domain bridge. Signals used: m_awvalid/s_awready/m_awadr/m_awlen; m_wvalid/s_wready/m_wdata/m_wlast; s_bvalid/m_bready; m_arvalid/s_arready/m_aradr/m_arlen; s_rvalid/m_rready/s_rdata.

Function
REQ-007 SHALL store data in an internal synchronous single-port RAM of MEM_SIZE x DATA_WIDTH; word index = (byte address / (DATA_WIDTH/8)) mod MEM_SIZE; low byte-offset bits ignored.
REQ-008 SHALL implement FSM states IDLE, WRITE_BURST, WRITE_RESP, READ_BURST.
REQ-009 SHALL, in IDLE, assert s_awready only when the write is the granted request and s_arready only when the read is the granted request; both SHALL be 0 in every other state.
REQ-010 SHALL grant, in IDLE: write if only m_awvalid; read if only m_arvalid; if both, the type not served most recently. last_served resets to write, so read wins the first collision.
REQ-011 SHALL, on AW handshake, latch word index from m_awadr, load beat counter with m_awlen (8 bits; burst = m_awlen+1 beats, incrementing) and enter WRITE_BURST.
REQ-012 SHALL, in WRITE_BURST, hold s_wready=1; each W handshake writes m_wdata to the current index, increments the index, decrements the counter.
REQ-013 SHALL end the write burst on the handshake with counter==0, ignoring m_wlast, and enter WRITE_RESP.
REQ-014 SHALL assert s_bvalid in the cycle after the last W handshake and hold it until m_bready is 1, then return to IDLE with s_bvalid=0 the following cycle.
REQ-015 SHALL, on AR handshake in cycle N, read the RAM at the m_aradr index, load the counter with m_arlen and enter READ_BURST with s_rvalid=1 and valid s_rdata in cycle N+1.
REQ-016 SHALL sustain one read beat per cycle while m_rready=1 by fetching index+1 on each R handshake.
REQ-017 SHALL hold s_rdata and s_rvalid stable while s_rvalid=1 and m_rready=0.
REQ-018 SHALL, on the R handshake with counter==0, return to IDLE with s_rvalid=0 the next cycle.
REQ-019 SHALL wrap the word index from MEM_SIZE-1 to 0 within a burst.
REQ-020 SHALL never assert a valid output combinationally from a ready input; readies may depend on valids.
REQ-021 SHALL, with m_awlen=0 or m_arlen=0, perform exactly one beat.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-burst, force IDLE, last_served=write, and s_bvalid=s_rvalid=s_wready=0; s_awready and s_arready follow REQ-009 in IDLE.
REQ-023 SHALL NOT clear RAM contents on reset; beats completed before reset remain stored.

Verification
REQ-024 Single write: AW addr 0x10, len 0, W 0xDEADBEEF -> word 4 written; s_bvalid in cycle after W handshake; then AR 0x10, len 0 -> s_rdata 0xDEADBEEF one cycle after AR handshake.
REQ-025 Burst: write 8 beats 0..7 from addr 0x100, read 8 beats back with m_rready held 1 -> 8 consecutive s_rvalid cycles returning 0..7 in order.
REQ-026 Backpressure: 4-beat read, m_rready toggled 1,0,0,1,... -> s_rdata stable during stalls; exactly 4 handshakes, values correct.
REQ-027 Collision: m_awvalid and m_arvalid both asserted from reset -> read granted first, then write; repeated collision alternates.
REQ-028 Wrap: MEM_SIZE=16, 4-beat write from word 14 -> words 14, 15, 0, 1 written.
REQ-029 Reset mid-burst: reset after beat 2 of a 4-beat write -> IDLE, s_wready=0; new read returns beats 0..1 written, beats 2..3 unchanged.
